// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the 31-instruction MIPS core.
// Strobes are combinational from state/code/zero/acks; state, wait counter, count and fault are registered.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      code,
   input  logic             zero,
   input  logic             im_ack,
   input  logic             dm_ack,
   output logic             im_req,
   output logic             ir_we,
   output logic             ab_we,
   output logic             alu_out_we,
   output logic             mdr_we,
   output logic             dm_req,
   output logic             dm_r,
   output logic             dm_w,
   output logic             rf_w,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             retire,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       fault
);

   localparam int unsigned WAIT_W = 8;

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [1:0] F_NONE    = 2'd0;
   localparam logic [1:0] F_ILLEGAL = 2'd1;
   localparam logic [1:0] F_IM_TO   = 2'd2;
   localparam logic [1:0] F_DM_TO   = 2'd3;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   logic [2:0]        state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_next;
   logic [1:0]        fault_next;
   logic              halted_next;
   logic              code_legal;
   logic              timeout_hit;
   logic              is_jump;
   logic              is_branch;
   logic              is_mem;
   logic              taken;

   // Exactly one bit set within the 31 defined instruction slots.
   assign code_legal  = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0) && !code[31];
   // This cycle is the TIMEOUT-th consecutive one without an ack.
   assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign is_jump     = code[16] | code[29] | code[30];
   assign is_branch   = code[24] | code[25];
   assign is_mem      = code[22] | code[23];
   assign taken       = code[24] ? zero : !zero;

   always_comb begin
      im_req      = 1'b0;
      ir_we       = 1'b0;
      ab_we       = 1'b0;
      alu_out_we  = 1'b0;
      mdr_we      = 1'b0;
      dm_req      = 1'b0;
      dm_r        = 1'b0;
      dm_w        = 1'b0;
      rf_w        = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_SEQ;
      retire      = 1'b0;
      state_next  = state;
      fault_next  = fault;
      halted_next = halted;

      case (state)
         S_IF: begin
            im_req = 1'b1;
            if (im_ack) begin
               ir_we      = 1'b1;
               state_next = S_ID;
            end else if (timeout_hit) begin
               state_next  = S_HALT;
               fault_next  = F_IM_TO;
               halted_next = 1'b1;
            end
         end
         S_ID: begin
            ab_we = 1'b1;
            if (!code_legal) begin
               state_next  = S_HALT;
               fault_next  = F_ILLEGAL;
               halted_next = 1'b1;
            end else if (is_jump) begin
               pc_we      = 1'b1;
               pc_src     = code[16] ? PC_RS : PC_JUMP;
               rf_w       = code[30];
               retire     = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_EX;
            end
         end
         S_EX: begin
            alu_out_we = 1'b1;
            if (is_branch) begin
               pc_we      = 1'b1;
               pc_src     = taken ? PC_BRANCH : PC_SEQ;
               retire     = 1'b1;
               state_next = S_IF;
            end else if (is_mem) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            dm_req = 1'b1;
            dm_r   = code[22];
            dm_w   = code[23];
            if (dm_ack) begin
               if (code[22]) begin
                  mdr_we     = 1'b1;
                  state_next = S_WB;
               end else begin
                  pc_we      = 1'b1;
                  retire     = 1'b1;
                  state_next = S_IF;
               end
            end else if (timeout_hit) begin
               state_next  = S_HALT;
               fault_next  = F_DM_TO;
               halted_next = 1'b1;
            end
         end
         S_WB: begin
            rf_w       = 1'b1;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_IF;
         end
         S_HALT: begin
            halted_next = 1'b1;
         end
         default: begin
            // Unreachable encodings are treated as a decode fault.
            state_next  = S_HALT;
            fault_next  = F_ILLEGAL;
            halted_next = 1'b1;
         end
      endcase

      if (state_next != state) begin
         wait_next = '0;
      end else if ((state == S_IF) || (state == S_MEM)) begin
         wait_next = wait_cnt + WAIT_W'(1);
      end else begin
         wait_next = '0;
      end

      // Asynchronous reset must silence every strobe immediately, not just at the next edge.
      if (rst) begin
         im_req     = 1'b0;
         ir_we      = 1'b0;
         ab_we      = 1'b0;
         alu_out_we = 1'b0;
         mdr_we     = 1'b0;
         dm_req     = 1'b0;
         dm_r       = 1'b0;
         dm_w       = 1'b0;
         rf_w       = 1'b0;
         pc_we      = 1'b0;
         pc_src     = PC_SEQ;
         retire     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IF;
         wait_cnt  <= '0;
         instr_cnt <= '0;
         fault     <= F_NONE;
         halted    <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         fault    <= fault_next;
         halted   <= halted_next;
         if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus random
// instruction streams compared cycle-by-cycle against a per-instruction trace model.
module tb_multicycle_sequencer;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned CNT_MASK = (1 << CW) - 1;

   localparam logic [2:0] ST_IF   = 3'd0;
   localparam logic [2:0] ST_ID   = 3'd1;
   localparam logic [2:0] ST_EX   = 3'd2;
   localparam logic [2:0] ST_MEM  = 3'd3;
   localparam logic [2:0] ST_WB   = 3'd4;
   localparam logic [2:0] ST_HALT = 3'd5;

   typedef struct packed {
      logic       im_req;
      logic       ir_we;
      logic       ab_we;
      logic       alu_out_we;
      logic       mdr_we;
      logic       dm_req;
      logic       dm_r;
      logic       dm_w;
      logic       rf_w;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       retire;
   } strb_t;

   typedef struct packed {
      logic [2:0] st;
      logic       ia;
      logic       da;
      strb_t      s;
   } step_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   code = 32'd0;
   logic          zero = 1'b0;
   logic          im_ack = 1'b0;
   logic          dm_ack = 1'b0;
   logic          im_req, ir_we, ab_we, alu_out_we, mdr_we, dm_req, dm_r, dm_w, rf_w, pc_we, retire;
   logic [1:0]    pc_src;
   logic [CW-1:0] instr_cnt;
   logic [2:0]    state;
   logic          halted;
   logic [1:0]    fault;
   strb_t         obs;

   int     checks = 0;
   int     failures = 0;
   int     exp_cnt = 0;
   step_t  tr[$];

   always #5 clk = ~clk;

   assign obs = {im_req, ir_we, ab_we, alu_out_we, mdr_we, dm_req, dm_r, dm_w, rf_w, pc_we, pc_src, retire};

   multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .code(code), .zero(zero), .im_ack(im_ack), .dm_ack(dm_ack),
      .im_req(im_req), .ir_we(ir_we), .ab_we(ab_we), .alu_out_we(alu_out_we), .mdr_we(mdr_we),
      .dm_req(dm_req), .dm_r(dm_r), .dm_w(dm_w), .rf_w(rf_w), .pc_we(pc_we), .pc_src(pc_src),
      .retire(retire), .instr_cnt(instr_cnt), .state(state), .halted(halted), .fault(fault)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void push(input logic [2:0] st, input logic ia, input logic da, input strb_t s);
      step_t e;
      e.st = st;
      e.ia = ia;
      e.da = da;
      e.s  = s;
      tr.push_back(e);
   endfunction

   // Expected cycle list for one instruction, built from its class and the ack delays.
   function automatic void build(input logic [31:0] c, input logic z, input int iw, input int dw);
      strb_t s;
      logic  jump, branch, mem, taken;
      jump   = c[16] | c[29] | c[30];
      branch = c[24] | c[25];
      mem    = c[22] | c[23];
      tr.delete();
      s = '0;
      s.im_req = 1'b1;
      for (int i = 0; i < iw; i++) push(ST_IF, 1'b0, 1'b0, s);
      s.ir_we = 1'b1;
      push(ST_IF, 1'b1, 1'b0, s);
      s = '0;
      s.ab_we = 1'b1;
      if (jump) begin
         s.pc_we  = 1'b1;
         s.retire = 1'b1;
         s.pc_src = c[16] ? 2'd3 : 2'd2;
         s.rf_w   = c[30];
      end
      push(ST_ID, 1'b0, 1'b0, s);
      if (jump) return;
      s = '0;
      s.alu_out_we = 1'b1;
      if (branch) begin
         taken    = c[24] ? z : !z;
         s.pc_we  = 1'b1;
         s.retire = 1'b1;
         s.pc_src = taken ? 2'd1 : 2'd0;
      end
      push(ST_EX, 1'b0, 1'b0, s);
      if (branch) return;
      if (mem) begin
         s = '0;
         s.dm_req = 1'b1;
         s.dm_r   = c[22];
         s.dm_w   = c[23];
         for (int i = 0; i < dw; i++) push(ST_MEM, 1'b0, 1'b0, s);
         if (c[22]) s.mdr_we = 1'b1;
         else begin
            s.pc_we  = 1'b1;
            s.retire = 1'b1;
         end
         push(ST_MEM, 1'b0, 1'b1, s);
         if (c[23]) return;
      end
      s = '0;
      s.rf_w   = 1'b1;
      s.pc_we  = 1'b1;
      s.retire = 1'b1;
      push(ST_WB, 1'b0, 1'b0, s);
   endfunction

   // Entered and left at posedge+1; drives acks, checks combinational outputs mid-cycle.
   task automatic run_trace(input string tag);
      foreach (tr[i]) begin
         im_ack = tr[i].ia;
         dm_ack = tr[i].da;
         #3;
         check({tag, "_state"}, 32'(state), 32'(tr[i].st));
         check({tag, "_strobes"}, 32'(obs), 32'(tr[i].s));
         if (tr[i].s.retire) exp_cnt++;
         @(posedge clk);
         #1;
      end
      im_ack = 1'b0;
      dm_ack = 1'b0;
   endtask

   task automatic run_instr(input string tag, input logic [31:0] c, input logic z, input int iw, input int dw);
      code = c;
      zero = z;
      build(c, z, iw, dw);
      run_trace(tag);
      check({tag, "_next_if"}, 32'(state), 32'(ST_IF));
      check({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt) & CNT_MASK);
      check({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   task automatic reset_dut(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_rst_state"}, 32'(state), 32'(ST_IF));
      check({tag, "_rst_strobes"}, 32'(obs), 32'd0);
      check({tag, "_rst_cnt"}, 32'(instr_cnt), 32'd0);
      check({tag, "_rst_fault"}, 32'(fault), 32'd0);
      check({tag, "_rst_halted"}, 32'(halted), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic check_halt(input string tag, input logic [1:0] f);
      #1;
      check({tag, "_halt_state"}, 32'(state), 32'(ST_HALT));
      check({tag, "_halt_strobes"}, 32'(obs), 32'd0);
      check({tag, "_halt_fault"}, 32'(fault), 32'(f));
      check({tag, "_halt_flag"}, 32'(halted), 32'd1);
      check({tag, "_halt_cnt"}, 32'(instr_cnt), 32'(exp_cnt) & CNT_MASK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      strb_t s;
      logic [31:0] c;
      logic [31:0] illegal;
      illegal = 32'h0000_0003;

      #2;
      reset_dut("init");

      run_instr("add", 32'd1 << 0, 1'b0, 0, 0);
      run_instr("lw_wait2", 32'd1 << 22, 1'b0, 0, 2);
      run_instr("beq_taken", 32'd1 << 24, 1'b1, 0, 0);
      run_instr("beq_not", 32'd1 << 24, 1'b0, 0, 0);
      run_instr("bne_taken", 32'd1 << 25, 1'b0, 1, 0);
      run_instr("jal", 32'd1 << 30, 1'b0, 0, 0);
      run_instr("jr", 32'd1 << 16, 1'b0, 0, 0);
      run_instr("j", 32'd1 << 29, 1'b0, 2, 0);
      run_instr("sw_late_ack", 32'd1 << 23, 1'b0, 3, 3);

      // Random legal instructions; ack delays up to TIMEOUT-1 so the last-cycle ack must win.
      for (int n = 0; n < 60; n++) begin
         c = 32'd1 << $urandom_range(30, 0);
         run_instr("rand", c, 1'($urandom_range(1, 0)), int'($urandom_range(TO - 1, 0)),
                   int'($urandom_range(TO - 1, 0)));
      end

      // Reset in the middle of a stalled SW.
      code = 32'd1 << 23;
      tr.delete();
      s = '0; s.im_req = 1'b1; s.ir_we = 1'b1; push(ST_IF, 1'b1, 1'b0, s);
      s = '0; s.ab_we = 1'b1; push(ST_ID, 1'b0, 1'b0, s);
      s = '0; s.alu_out_we = 1'b1; push(ST_EX, 1'b0, 1'b0, s);
      s = '0; s.dm_req = 1'b1; s.dm_w = 1'b1;
      push(ST_MEM, 1'b0, 1'b0, s);
      push(ST_MEM, 1'b0, 1'b0, s);
      run_trace("sw_rst");
      check("sw_rst_req_before", 32'(dm_req), 32'd1);
      reset_dut("sw_rst");

      // SW with dm_ack never arriving.
      code = 32'd1 << 23;
      tr.delete();
      s = '0; s.im_req = 1'b1; s.ir_we = 1'b1; push(ST_IF, 1'b1, 1'b0, s);
      s = '0; s.ab_we = 1'b1; push(ST_ID, 1'b0, 1'b0, s);
      s = '0; s.alu_out_we = 1'b1; push(ST_EX, 1'b0, 1'b0, s);
      s = '0; s.dm_req = 1'b1; s.dm_w = 1'b1;
      for (int i = 0; i < int'(TO); i++) push(ST_MEM, 1'b0, 1'b0, s);
      run_trace("dm_to");
      check_halt("dm_to", 2'd3);
      reset_dut("dm_to");

      // Fetch with im_ack never arriving.
      run_instr("pre_im_to", 32'd1 << 5, 1'b0, 0, 0);
      code = 32'd1 << 5;
      tr.delete();
      s = '0; s.im_req = 1'b1;
      for (int i = 0; i < int'(TO); i++) push(ST_IF, 1'b0, 1'b0, s);
      run_trace("im_to");
      check_halt("im_to", 2'd2);
      reset_dut("im_to");

      // Two-hot code faults in ID; later acks must be ignored.
      run_instr("pre_ill", 32'd1 << 17, 1'b0, 0, 0);
      code = illegal;
      tr.delete();
      s = '0; s.im_req = 1'b1; s.ir_we = 1'b1; push(ST_IF, 1'b1, 1'b0, s);
      s = '0; s.ab_we = 1'b1; push(ST_ID, 1'b0, 1'b0, s);
      s = '0;
      for (int i = 0; i < 4; i++) push(ST_HALT, 1'b1, 1'b1, s);
      run_trace("illegal");
      check_halt("illegal", 2'd1);
      reset_dut("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
